// File: rtl/plot_capture_pkg.sv
// Shared constants, types and address helpers for the plot capture framebuffer.
`timescale 1ns/1ps
package plot_capture_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;

    localparam logic [7:0]        X_LIMIT   = 8'(SCREEN_W);
    localparam logic [6:0]        Y_LIMIT   = 7'(SCREEN_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } cap_state_t;

    typedef struct packed {
        logic [7:0]          x;
        logic [6:0]          y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // Bounds use the full input widths, so nothing wraps into a neighbouring row.
    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
        return (x < X_LIMIT) && (y < Y_LIMIT);
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one synchronous write, one registered read,
// read-before-write on a shared address.
`timescale 1ns/1ps
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int WIDTH = 3,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/plot_capture.sv
// Captures plotted pixels into a 160x120x3 framebuffer with auto-clear, clipping,
// a one-cycle-latency read port and saturating statistics counters.
`timescale 1ns/1ps
module plot_capture
    import plot_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                plot,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                busy,
    output logic                clear_done,
    input  logic                rd_en,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic                rd_valid,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic [CNT_W-1:0]    plot_count,
    output logic [CNT_W-1:0]    clip_count,
    output logic [CNT_W-1:0]    drop_count
);

    cap_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   clear_addr_reg, clear_addr_next;
    logic [COLOUR_W-1:0] clear_colour_reg, clear_colour_next;
    logic                clear_done_reg, clear_done_next;
    logic                clear_start;

    pixel_t              wr_pix_reg;
    logic                wr_valid_reg;
    logic                rd_valid_reg, rd_off_reg;

    logic                plot_idle, accept_ev, clip_ev, drop_ev;
    logic                rd_on;
    logic                ram_wr_en;
    logic [ADDR_W-1:0]   ram_wr_addr;
    logic [COLOUR_W-1:0] ram_wr_data, ram_rd_data;

    assign busy       = (state_reg == CLEAR);
    assign clear_done = clear_done_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= CLEAR;
            clear_addr_reg   <= '0;
            clear_colour_reg <= '0;
            clear_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            clear_addr_reg   <= clear_addr_next;
            clear_colour_reg <= clear_colour_next;
            clear_done_reg   <= clear_done_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        clear_addr_next   = clear_addr_reg;
        clear_colour_next = clear_colour_reg;
        clear_done_next   = 1'b0;
        clear_start       = 1'b0;
        case (state_reg)
            CLEAR: begin
                clear_addr_next = clear_addr_reg + ADDR_W'(1);
                if (clear_addr_reg == LAST_ADDR) begin
                    clear_addr_next = '0;
                    clear_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    clear_start       = 1'b1;
                    clear_colour_next = clear_colour;
                    clear_addr_next   = '0;
                    state_next        = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // A clear request in the same idle cycle swallows the plot entirely.
    assign plot_idle = plot && (state_reg == IDLE) && !clear_req;
    assign accept_ev = plot_idle && on_screen(vga_x, vga_y);
    assign clip_ev   = plot_idle && !on_screen(vga_x, vga_y);
    assign drop_ev   = plot && busy;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_valid_reg <= 1'b0;
            wr_pix_reg   <= '0;
        end else begin
            wr_valid_reg <= accept_ev;
            if (accept_ev) begin
                wr_pix_reg <= '{x: vga_x, y: vga_y, colour: vga_colour};
            end
        end
    end

    assign ram_wr_en   = busy || wr_valid_reg;
    assign ram_wr_addr = busy ? clear_addr_reg : pix_addr(wr_pix_reg.x, wr_pix_reg.y);
    assign ram_wr_data = busy ? clear_colour_reg : wr_pix_reg.colour;

    assign rd_on = on_screen(rd_x, rd_y);

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (COLOUR_W),
        .AW    (ADDR_W)
    ) u_fb_ram (
        .clk     (clock),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (rd_en && rd_on),
        .rd_addr (rd_on ? pix_addr(rd_x, rd_y) : '0),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_valid_reg <= 1'b0;
            rd_off_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            rd_off_reg   <= !rd_on;
        end
    end

    // RAM output is never reset, so gate it until a valid on-screen read lands.
    assign rd_valid  = rd_valid_reg;
    assign rd_colour = (rd_valid_reg && !rd_off_reg) ? ram_rd_data : '0;

    logic [2:0]            cnt_inc;
    logic [2:0][CNT_W-1:0] cnt_bus;

    assign cnt_inc = {drop_ev, clip_ev, accept_ev};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                cnt_reg <= '0;
            end else if (clear_start) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
        assign cnt_bus[gi] = cnt_reg;
    end

    assign plot_count = cnt_bus[0];
    assign clip_count = cnt_bus[1];
    assign drop_count = cnt_bus[2];

endmodule
